// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and default widths for the
// binary-to-Gray producer and the Gray sync/decode consumer.
package gray_pkg;

  localparam int DEF_WIDTH       = 4;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_CNT_W       = 8;

  // Helpers work on any width up to 32 bits when zero-extended.
  function automatic logic [31:0] bin2gray(
    input logic [31:0] b
  );
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(
    input logic [31:0] g
  );
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [5:0] popcount(
    input logic [31:0] v
  );
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) begin
      c = c + 6'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/gray_to_binary_converter.sv
// Combinational Gray-to-binary decode, WIDTH bits.
// Each binary bit is the XOR of all Gray bits at or above it.
module gray_to_binary_converter #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] gray_i,
  output logic [WIDTH-1:0] bin_o
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign bin_o[i] = ^gray_i[WIDTH-1:i];
  end

endmodule

// File: rtl/gray_sync_decoder.sv
// Multi-flop synchronizer for an async Gray word, followed by
// binary decode, change pulse, signed step and step-error count.
module gray_sync_decoder
  import gray_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] gray_in,
  input  logic             clear_err,
  output logic [WIDTH-1:0] gray_sync,
  output logic [WIDTH-1:0] bin_out,
  output logic             valid,
  output logic [WIDTH-1:0] delta,
  output logic             step_err,
  output logic [CNT_W-1:0] err_count
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] delta_q, delta_d;
  logic             valid_q, valid_d;
  logic             serr_q, serr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] dec_bin;
  logic             changed;
  logic             multi;

  assign gray_sync = sync_q[SYNC_STAGES-1];

  gray_to_binary_converter #(
    .WIDTH(WIDTH)
  ) u_g2b (
    .gray_i(gray_sync),
    .bin_o (dec_bin)
  );

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], gray_in};
  end

  always_comb begin
    changed = gray_sync != prev_q;
    multi   = popcount(32'(gray_sync ^ prev_q)) > 6'd1;
    prev_d  = gray_sync;
    bin_d   = bin_q;
    delta_d = delta_q;
    valid_d = 1'b0;
    serr_d  = 1'b0;
    if (changed) begin
      bin_d   = dec_bin;
      delta_d = dec_bin - bin_q;
      valid_d = 1'b1;
      serr_d  = multi;
    end
  end

  // Clear wins over history but still records a same-cycle error.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_err) begin
      cnt_d = serr_d ? CNT_W'(1) : '0;
    end else if (serr_d && cnt_q != {CNT_W{1'b1}}) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      prev_q  <= '0;
      bin_q   <= '0;
      delta_q <= '0;
      valid_q <= 1'b0;
      serr_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q  <= sync_d;
      prev_q  <= prev_d;
      bin_q   <= bin_d;
      delta_q <= delta_d;
      valid_q <= valid_d;
      serr_q  <= serr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bin_out   = bin_q;
  assign delta     = delta_q;
  assign valid     = valid_q;
  assign step_err  = serr_q;
  assign err_count = cnt_q;

endmodule

// File: tb/tb_gray_sync_decoder.sv
// Directed-vector bench for gray_sync_decoder (WIDTH=4,
// SYNC_STAGES=2, CNT_W=2 so saturation is reachable).
module tb_gray_sync_decoder;

  logic       clk;
  logic       rst_n;
  logic [3:0] gray_in;
  logic       clear_err;
  logic [3:0] gray_sync;
  logic [3:0] bin_out;
  logic       valid;
  logic [3:0] delta;
  logic       step_err;
  logic [1:0] err_count;

  int n_vec;
  int n_err;

  gray_sync_decoder #(
    .WIDTH      (4),
    .SYNC_STAGES(2),
    .CNT_W      (2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .gray_in  (gray_in),
    .clear_err(clear_err),
    .gray_sync(gray_sync),
    .bin_out  (bin_out),
    .valid    (valid),
    .delta    (delta),
    .step_err (step_err),
    .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic outs(
    input string      tag,
    input logic [3:0] b,
    input logic       v,
    input logic [3:0] d,
    input logic       s,
    input logic [1:0] c
  );
    chk({tag, ".bin"}, 32'(bin_out), 32'(b));
    chk({tag, ".valid"}, 32'(valid), 32'(v));
    chk({tag, ".delta"}, 32'(delta), 32'(d));
    chk({tag, ".serr"}, 32'(step_err), 32'(s));
    chk({tag, ".cnt"}, 32'(err_count), 32'(c));
  endtask

  // Drive one Gray value, hold it 4 clks, check timing and results.
  task automatic apply(
    input string      tag,
    input logic [3:0] g,
    input logic [3:0] b,
    input logic [3:0] d,
    input logic       s,
    input logic [1:0] c,
    input logic       clr
  );
    @(negedge clk);
    gray_in = g;
    tick();
    tick();
    chk({tag, ".sync"}, 32'(gray_sync), 32'(g));
    chk({tag, ".early"}, 32'(valid), 32'd0);
    if (clr) begin
      @(negedge clk);
      clear_err = 1'b1;
    end
    tick();
    outs(tag, b, 1'b1, d, s, c);
    @(negedge clk);
    clear_err = 1'b0;
    tick();
    chk({tag, ".vdrop"}, 32'(valid), 32'd0);
    chk({tag, ".sdrop"}, 32'(step_err), 32'd0);
    tick();
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    gray_in   = 4'b1011;
    clear_err = 1'b0;
    repeat (3) tick();
    outs("rst", 4'h0, 1'b0, 4'h0, 1'b0, 2'd0);
    chk("rst.sync", 32'(gray_sync), 32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    chk("first.sync", 32'(gray_sync), 32'hb);
    chk("first.early", 32'(valid), 32'd0);
    tick();
    outs("first", 4'b1101, 1'b1, 4'b1101, 1'b1, 2'd1);
    tick();
    chk("first.vdrop", 32'(valid), 32'd0);
    tick();

    apply("to0", 4'b0000, 4'd0, 4'b0011, 1'b1, 2'd2, 1'b0);
    apply("up1", 4'b0001, 4'd1, 4'b0001, 1'b0, 2'd2, 1'b0);
    apply("up2", 4'b0011, 4'd2, 4'b0001, 1'b0, 2'd2, 1'b0);
    apply("up3", 4'b0010, 4'd3, 4'b0001, 1'b0, 2'd2, 1'b0);
    apply("to15", 4'b1000, 4'd15, 4'b1100, 1'b1, 2'd3, 1'b0);
    apply("wrap", 4'b0000, 4'd0, 4'b0001, 1'b0, 2'd3, 1'b0);
    apply("w1", 4'b0001, 4'd1, 4'b0001, 1'b0, 2'd3, 1'b0);
    apply("w2", 4'b0011, 4'd2, 4'b0001, 1'b0, 2'd3, 1'b0);
    apply("down", 4'b0001, 4'd1, 4'b1111, 1'b0, 2'd3, 1'b0);

    @(negedge clk);
    clear_err = 1'b1;
    tick();
    chk("qclr.cnt", 32'(err_count), 32'd0);
    chk("qclr.bin", 32'(bin_out), 32'd1);
    @(negedge clk);
    clear_err = 1'b0;

    apply("jump", 4'b0111, 4'b0101, 4'b0100, 1'b1, 2'd1, 1'b0);
    apply("sat2", 4'b0000, 4'd0, 4'b1011, 1'b1, 2'd2, 1'b0);
    apply("sat3", 4'b0111, 4'b0101, 4'b0101, 1'b1, 2'd3, 1'b0);
    apply("sat4", 4'b0000, 4'd0, 4'b1011, 1'b1, 2'd3, 1'b0);
    apply("sat5", 4'b0111, 4'b0101, 4'b0101, 1'b1, 2'd3, 1'b0);
    apply("clrhit", 4'b0000, 4'd0, 4'b1011, 1'b1, 2'd1, 1'b1);
    apply("pre", 4'b0001, 4'd1, 4'b0001, 1'b0, 2'd1, 1'b0);

    @(negedge clk);
    gray_in = 4'b0011;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    outs("arst", 4'h0, 1'b0, 4'h0, 1'b0, 2'd0);
    chk("arst.sync", 32'(gray_sync), 32'd0);
    gray_in = 4'b0000;
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("post.valid", 32'(valid), 32'd0);
    end
    chk("post.bin", 32'(bin_out), 32'd0);
    chk("post.cnt", 32'(err_count), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/gray_sync_decoder.md
Name: gray_sync_decoder

Overview:
- Downstream consumer of the binary-to-Gray stage.
- Takes a Gray-coded value that may be asynchronous to clk, such as a pointer or counter from another domain, and brings it in through a multi-flop synchronizer.
- Decodes the synchronized value back to binary, reports each change with a one-cycle valid pulse and the signed step size, and flags and counts illegal multi-bit Gray transitions.

Parameters:
- WIDTH, 4, Gray/binary word width (≥2).
- SYNC_STAGES, 2, synchronizer flop depth (≥2).
- CNT_W, 8, width of the saturating error counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- gray_in  input  WIDTH  Gray-coded value; may change asynchronously to clk.
- clear_err  input  1  synchronous clear of err_count.
- gray_sync  output  WIDTH  last synchronizer stage (Gray).
- bin_out  output  WIDTH  registered binary decode of gray_sync.
- valid  output  1  one-cycle pulse when bin_out takes a new value.
- delta  output  WIDTH  (new bin − previous bin) mod 2^WIDTH; meaningful while valid=1.
- step_err  output  1  one-cycle pulse: the Gray change had Hamming distance >1.
- err_count  output  CNT_W  saturating count of step_err pulses.

Behaviour:
- Reset:
  - rst_n low clears all synchronizer flops, gray_sync, bin_out, delta, valid, step_err and err_count to 0, immediately and regardless of clk.
  - Reset asserted mid-operation discards any in-flight value.
  - The first post-reset comparison is against 0000.
- Synchronizer:
  - SYNC_STAGES flops in series on gray_in; gray_sync is the last stage.
  - No logic between the stages.
- Decode stage, one register after gray_sync:
  - bin[WIDTH−1] = g[WIDTH−1].
  - bin[i] = bin[i+1] XOR g[i].
- Latency: a stable change on gray_in sampled at edge k shows on gray_sync after edge k+SYNC_STAGES−1, and on bin_out/valid/delta/step_err after edge k+SYNC_STAGES.
- Change detect:
  - The decode stage keeps prev_gray, the gray_sync value from the previous cycle.
  - If gray_sync ≠ prev_gray, then on the next edge:
    - bin_out ← decode(gray_sync)
    - valid ← 1
    - delta ← decode(gray_sync) − bin_out, truncated to WIDTH.
  - Otherwise valid ← 0, and bin_out and delta hold.
- Legal steps:
  - A legal Gray step gives delta = 1 (up) or all-ones (down).
  - Wrap is legal in both directions: gray 1000→0000 is bin 15→0, delta=0001; the reverse gives delta=1111.
- Error detect:
  - step_err ← 1 in the same cycle as valid when popcount(gray_sync XOR prev_gray) > 1.
  - bin_out still updates to the decoded value; the error is flagged, not filtered.
- err_count:
  - Increments on each step_err pulse and saturates at 2^CNT_W−1 (no wrap).
  - When clear_err is asserted, err_count ← 0, or ← 1 if a step_err pulse is generated in that same cycle.
  - clear_err has no effect on other outputs.
- Held input: valid, step_err and the counter stay idle indefinitely.
- Input rate: gray_in changes faster than once per clk are outside the contract. Intermediate values may be skipped, and any resulting multi-bit jump is reported via step_err.

Decomposition:
- Package gray_pkg holds:
  - bin2gray and gray2bin functions, parameterised by width.
  - A popcount function.
  - Default WIDTH/SYNC_STAGES/CNT_W localparams shared with the binary-to-Gray stage.
- One sub-module, gray_to_binary_converter: purely combinational, WIDTH-parameterised, the inverse of the existing converter. Instantiated once in the decode stage; it is also the bench reference model.

Test Plan:
- Reset and first value: hold rst_n=0 with gray_in=1011 → all outputs 0. Release; 3 edges later bin_out=1101, valid=1, delta=1101, step_err=1 (0000→1011 is 3 bits), err_count=1.
- Up count: drive gray 0000,0001,0011,0010, each held 4 clks → bin_out 0,1,2,3 with a one-cycle valid per change, delta=0001, step_err never asserted, err_count unchanged.
- Wrap and down: gray 1000 (bin 15) → 0000 gives bin_out=0, delta=0001. Then 0011→0001 gives bin_out=0001, delta=1111. No step_err in either case.
- Illegal jump: gray 0001→0111 → bin_out=0101, valid=1, step_err=1, err_count +1, delta=0100.
- Saturation and clear: CNT_W=2, force 5 illegal jumps → err_count sticks at 3. Pulse clear_err on a quiet cycle → 0. Pulse clear_err in the same cycle as an illegal jump's step_err → err_count=1.
- Async reset mid-flight: change gray_in, then assert rst_n one clk later between edges → outputs clear immediately, and no valid pulse appears after release while gray_in is held at 0000.
